// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
//   Shared constants for the frame sequencer: 2-bit state encodings and the
//   default frame geometry (640x480 beats) with its derived counter width.
package frame_seq_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t IDLE     = 2'd0;
  localparam fsm_state_t WAIT_SOF = 2'd1;
  localparam fsm_state_t STREAM   = 2'd2;
  localparam fsm_state_t FROZEN   = 2'd3;

  localparam int PIX_PER_FRAME_DEF = 307200;
  // One extra code so the counter can hold the saturated "frame full" value.
  localparam int CW_DEF = $clog2(PIX_PER_FRAME_DEF + 1);

endpackage

// File: rtl/frame_seq_ctrl_vsync.sv
// vsync_sync_edge
//   2-FF synchroniser for a slow strobe from another clock domain, followed
//   by an edge register. Rise/fall are single-cycle pulses valid in the
//   cycle after the synchronised level changes (3 edges after the input).
//   Reusable for HREF and other pclk-domain strobes.
// Ports:
//   i_top_clk      destination clock
//   w_rstn_btn_db  async active-low reset
//   i_async        raw strobe from the foreign domain
//   o_rise/o_fall  one-cycle edge pulses of the synchronised strobe
import frame_seq_pkg::*;

module vsync_sync_edge (
  input  logic i_top_clk,
  input  logic w_rstn_btn_db,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic sync_1;
  logic sync_2;
  logic sync_d;

  always_ff @(posedge i_top_clk or negedge w_rstn_btn_db) begin
    if (!w_rstn_btn_db) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_1 <= i_async;
      sync_2 <= sync_1;
      sync_d <= sync_2;
    end
  end

  assign o_rise = sync_2 & ~sync_d;
  assign o_fall = ~sync_2 & sync_d;

endmodule

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl
//   Frame-level gate on the cam_top -> vp_top valid/ready link. Pixels are
//   only passed between frame boundaries (falling edge of synchronised
//   VSYNC); supports continuous run, single-frame snapshot and freeze.
//   Counts beats per frame, flags short/long frames, counts frames.
// Ports:
//   i_top_clk, w_rstn_btn_db   clock, async active-low reset
//   i_cam_done                 camera configured (level)
//   i_vsync_async              raw camera VSYNC (pclk domain)
//   i_run / i_snap / i_err_clr user controls (level / pulse / pulse)
//   i_up_*, o_up_ready         upstream link from cam_top
//   o_dn_*, i_dn_ready         downstream link to vp_top
//   o_state                    current state
//   o_frame_done, o_frame_cnt  end-of-frame pulse, completed frame count
//   o_err_short, o_err_long    sticky frame-length errors
//
// state    | meaning
// IDLE     | camera not ready or not requested; upstream drained
// WAIT_SOF | armed, waiting for the next frame boundary
// STREAM   | passing beats of the current frame downstream
// FROZEN   | last frame held; upstream drained until run/snap
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int DW            = 12,
  parameter int PIX_PER_FRAME = PIX_PER_FRAME_DEF,
  parameter int CW            = CW_DEF
) (
  input  logic          i_top_clk,
  input  logic          w_rstn_btn_db,
  input  logic          i_cam_done,
  input  logic          i_vsync_async,
  input  logic          i_run,
  input  logic          i_snap,
  input  logic          i_err_clr,
  input  logic          i_up_valid,
  input  logic [DW-1:0] i_up_data,
  output logic          o_up_ready,
  output logic          o_dn_valid,
  output logic [DW-1:0] o_dn_data,
  input  logic          i_dn_ready,
  output logic [1:0]    o_state,
  output logic          o_frame_done,
  output logic [15:0]   o_frame_cnt,
  output logic          o_err_short,
  output logic          o_err_long
);

  localparam logic [CW-1:0] PPF = CW'(PIX_PER_FRAME);

  fsm_state_t    state_q;
  fsm_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic          snap_pend_q;
  logic          fb;
  logic          vs_rise_unused;
  logic          in_stream;
  logic          full;
  logic          pass_en;
  logic          beat_cnt;
  logic          drop;
  logic          eof;
  logic          short_frm;
  logic          snap_clr;

  vsync_sync_edge u_vsync (
    .i_top_clk     (i_top_clk),
    .w_rstn_btn_db (w_rstn_btn_db),
    .i_async       (i_vsync_async),
    .o_rise        (vs_rise_unused),
    .o_fall        (fb)
  );

  assign in_stream = (state_q == STREAM);
  assign full      = (cnt_q == PPF);
  assign pass_en   = in_stream && !full;

  // Pure combinational pass-through: valid/data hold as long as cam_top
  // holds them, so the downstream handshake rules are inherited from it.
  assign o_dn_data  = i_up_data;
  assign o_dn_valid = pass_en && i_up_valid;
  assign o_up_ready = pass_en ? i_dn_ready : 1'b1;

  assign beat_cnt = pass_en && i_up_valid && i_dn_ready;
  assign drop     = in_stream && full && i_up_valid;

  // A beat in the boundary cycle still belongs to the ending frame.
  assign short_frm = (cnt_q + CW'(beat_cnt)) < PPF;
  // Losing i_cam_done on the boundary cycle aborts the frame silently.
  assign eof       = in_stream && fb && i_cam_done;

  always_comb begin
    state_d = state_q;
    if (!i_cam_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, FROZEN: if (i_run || snap_pend_q) state_d = WAIT_SOF;
        WAIT_SOF:     if (fb) state_d = STREAM;
        STREAM:       if (fb && (snap_pend_q || !i_run)) state_d = FROZEN;
        default:      state_d = IDLE;
      endcase
    end
  end

  // Pending snapshot is consumed when we settle into IDLE or FROZEN; a new
  // request arriving in that same cycle is kept so it is not lost.
  assign snap_clr = (state_d != state_q) && ((state_d == IDLE) || (state_d == FROZEN));

  always_ff @(posedge i_top_clk or negedge w_rstn_btn_db) begin
    if (!w_rstn_btn_db) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_pend_q  <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_short  <= 1'b0;
      o_err_long   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_pend_q <= i_snap | (snap_pend_q & ~snap_clr);

      if (!in_stream || fb || !i_cam_done) begin
        cnt_q <= '0;
      end else if (beat_cnt) begin
        cnt_q <= cnt_q + 1'b1;
      end

      o_frame_done <= eof;
      o_frame_cnt  <= o_frame_cnt + 16'(eof);

      // Set has priority over a same-cycle clear.
      o_err_short <= (eof && short_frm) | (o_err_short & ~i_err_clr);
      o_err_long  <= drop | (o_err_long & ~i_err_clr);
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
module tb_frame_seq_ctrl;

  localparam int DW  = 12;
  localparam int PPF = 16;
  localparam int CW  = 5;

  logic          i_top_clk     = 1'b0;
  logic          w_rstn_btn_db = 1'b0;
  logic          i_cam_done    = 1'b0;
  logic          i_vsync_async = 1'b0;
  logic          i_run         = 1'b0;
  logic          i_snap        = 1'b0;
  logic          i_err_clr     = 1'b0;
  logic          i_up_valid    = 1'b0;
  logic [DW-1:0] i_up_data     = '0;
  logic          i_dn_ready    = 1'b0;
  logic          o_up_ready;
  logic          o_dn_valid;
  logic [DW-1:0] o_dn_data;
  logic [1:0]    o_state;
  logic          o_frame_done;
  logic [15:0]   o_frame_cnt;
  logic          o_err_short;
  logic          o_err_long;

  int total  = 0;
  int bad    = 0;
  int fd_cnt = 0;
  int sb_pos = 0;
  int n_acc;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] d;
  logic [DW-1:0] prev_d;
  bit            prev_stall;

  frame_seq_ctrl #(.DW(DW), .PIX_PER_FRAME(PPF), .CW(CW)) dut (
    .i_top_clk     (i_top_clk),
    .w_rstn_btn_db (w_rstn_btn_db),
    .i_cam_done    (i_cam_done),
    .i_vsync_async (i_vsync_async),
    .i_run         (i_run),
    .i_snap        (i_snap),
    .i_err_clr     (i_err_clr),
    .i_up_valid    (i_up_valid),
    .i_up_data     (i_up_data),
    .o_up_ready    (o_up_ready),
    .o_dn_valid    (o_dn_valid),
    .o_dn_data     (o_dn_data),
    .i_dn_ready    (i_dn_ready),
    .o_state       (o_state),
    .o_frame_done  (o_frame_done),
    .o_frame_cnt   (o_frame_cnt),
    .o_err_short   (o_err_short),
    .o_err_long    (o_err_long)
  );

  always #5 i_top_clk = ~i_top_clk;

  // Inputs change at posedge+2, so the negative edge sees a settled cycle.
  always @(negedge i_top_clk) begin
    if (w_rstn_btn_db) begin
      if (o_frame_done) fd_cnt++;
      if (o_dn_valid && i_dn_ready) got_q.push_back(o_dn_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_top_clk);
    #2;
  endtask

  // Leaves the synchronised falling edge pending: the caller's next cyc()
  // is the frame-boundary cycle.
  task automatic vs_pulse();
    i_vsync_async = 1'b1;
    repeat (4) cyc();
    i_vsync_async = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic beat(input logic [DW-1:0] dat, input bit pass);
    i_up_valid = 1'b1;
    i_up_data  = dat;
    i_dn_ready = 1'b1;
    #1;
    chk("beat_dn_valid", o_dn_valid, pass);
    if (pass) exp_q.push_back(dat);
    cyc();
    i_up_valid = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    chk(tag, got_q.size(), exp_q.size());
    for (int i = sb_pos; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk("sb_data", got_q[i], exp_q[i]);
    end
    sb_pos = exp_q.size();
  endtask

  initial begin
    // ---- reset state
    #12;
    chk("rst_state", o_state, 2'd0);
    chk("rst_dn_valid", o_dn_valid, 1'b0);
    chk("rst_up_ready", o_up_ready, 1'b1);
    chk("rst_frame_cnt", o_frame_cnt, 16'd0);
    chk("rst_errs", {o_err_short, o_err_long, o_frame_done}, 3'b000);
    cyc();
    w_rstn_btn_db = 1'b1;
    cyc();

    // ---- basic full frame
    i_cam_done = 1'b1;
    i_run      = 1'b1;
    cyc();
    chk("idle_to_wait", o_state, 2'd1);
    vs_pulse();
    chk("wait_hold", o_state, 2'd1);
    cyc();
    chk("wait_to_stream", o_state, 2'd2);
    for (int i = 0; i < 16; i++) beat(12'h100 + 12'(i), 1'b1);
    chk("cnt_before_fb", o_frame_cnt, 16'd0);
    vs_pulse();
    cyc();
    chk("f1_done", o_frame_done, 1'b1);
    chk("f1_cnt", o_frame_cnt, 16'd1);
    chk("f1_state", o_state, 2'd2);
    chk("f1_errs", {o_err_short, o_err_long}, 2'b00);
    cyc();
    chk("f1_done_pulse", o_frame_done, 1'b0);
    sb_check("sb_f1");

    // ---- short frame, clear, long frame
    for (int i = 0; i < 10; i++) beat(12'h200 + 12'(i), 1'b1);
    vs_pulse();
    cyc();
    chk("f2_short", o_err_short, 1'b1);
    chk("f2_cnt", o_frame_cnt, 16'd2);
    chk("f2_long", o_err_long, 1'b0);
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    chk("short_clr", o_err_short, 1'b0);
    for (int i = 0; i < 20; i++) begin
      i_up_valid = 1'b1;
      i_up_data  = 12'h400 + 12'(i);
      i_dn_ready = 1'b1;
      #1;
      chk("long_dn_valid", o_dn_valid, (i < 16));
      chk("long_up_ready", o_up_ready, 1'b1);
      if (i < 16) exp_q.push_back(12'h400 + 12'(i));
      cyc();
    end
    i_up_valid = 1'b0;
    chk("f3_long", o_err_long, 1'b1);
    sb_check("sb_f3");
    vs_pulse();
    cyc();
    chk("f3_cnt", o_frame_cnt, 16'd3);
    chk("f3_no_short", o_err_short, 1'b0);

    // ---- error clear coincident with a new drop: set wins
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    chk("long_clr", o_err_long, 1'b0);
    for (int i = 0; i < 16; i++) beat(12'h500 + 12'(i), 1'b1);
    i_err_clr = 1'b1;
    beat(12'h5FF, 1'b0);
    i_err_clr = 1'b0;
    chk("set_beats_clr", o_err_long, 1'b1);
    vs_pulse();
    cyc();
    chk("f4_cnt", o_frame_cnt, 16'd4);

    // ---- freeze, then one snapshot frame under backpressure
    i_run = 1'b0;
    vs_pulse();
    cyc();
    chk("f5_frozen", o_state, 2'd3);
    chk("f5_cnt", o_frame_cnt, 16'd5);
    chk("f5_short", o_err_short, 1'b1);
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    i_up_valid = 1'b1;
    i_dn_ready = 1'b1;
    #1;
    chk("frz_dn_valid", o_dn_valid, 1'b0);
    chk("frz_up_ready", o_up_ready, 1'b1);
    cyc();
    i_up_valid = 1'b0;
    chk("frz_stays", o_state, 2'd3);
    i_snap = 1'b1;
    cyc();
    i_snap = 1'b0;
    cyc();
    chk("snap_to_wait", o_state, 2'd1);
    vs_pulse();
    cyc();
    chk("snap_stream", o_state, 2'd2);
    d          = 12'h300;
    n_acc      = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    i_up_valid = 1'b1;
    for (int k = 0; k < 200 && n_acc < 16; k++) begin
      i_up_data  = d;
      i_dn_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("bp_hold_valid", o_dn_valid, 1'b1);
        chk("bp_hold_data", o_dn_data, prev_d);
      end else begin
        chk("bp_valid", o_dn_valid, 1'b1);
      end
      prev_stall = !i_dn_ready;
      prev_d     = d;
      if (i_dn_ready) begin
        exp_q.push_back(d);
        n_acc++;
      end
      cyc();
      if (!prev_stall) d = d + 12'd1;
    end
    i_up_valid = 1'b0;
    i_dn_ready = 1'b1;
    chk("bp_accepted", n_acc, 16);
    sb_check("sb_snap");
    vs_pulse();
    cyc();
    chk("snap_frozen", o_state, 2'd3);
    chk("f6_cnt", o_frame_cnt, 16'd6);
    chk("f6_no_short", o_err_short, 1'b0);
    cyc();
    chk("snap_once", o_state, 2'd3);

    // ---- cam_done dropped mid-frame
    i_run = 1'b1;
    cyc();
    chk("frz_to_wait", o_state, 2'd1);
    vs_pulse();
    cyc();
    for (int i = 0; i < 7; i++) beat(12'h600 + 12'(i), 1'b1);
    i_cam_done = 1'b0;
    cyc();
    chk("drop_idle", o_state, 2'd0);
    chk("drop_no_done", o_frame_done, 1'b0);
    chk("drop_cnt", o_frame_cnt, 16'd6);

    // ---- boundary and cam_done loss in the same cycle
    i_cam_done = 1'b1;
    cyc();
    vs_pulse();
    cyc();
    chk("rearm_stream", o_state, 2'd2);
    for (int i = 0; i < 3; i++) beat(12'h700 + 12'(i), 1'b1);
    vs_pulse();
    i_cam_done = 1'b0;
    cyc();
    chk("fbdrop_idle", o_state, 2'd0);
    chk("fbdrop_no_done", o_frame_done, 1'b0);
    chk("fbdrop_cnt", o_frame_cnt, 16'd6);
    chk("fd_pulses", fd_cnt, 6);
    sb_check("sb_drop");

    // ---- async reset in the middle of a beat
    i_cam_done = 1'b1;
    cyc();
    vs_pulse();
    cyc();
    i_up_valid = 1'b1;
    i_up_data  = 12'hABC;
    i_dn_ready = 1'b0;
    #1;
    chk("pre_rst_valid", o_dn_valid, 1'b1);
    w_rstn_btn_db = 1'b0;
    #1;
    chk("mid_rst_valid", o_dn_valid, 1'b0);
    chk("mid_rst_ready", o_up_ready, 1'b1);
    chk("mid_rst_state", o_state, 2'd0);
    chk("mid_rst_cnt", o_frame_cnt, 16'd0);
    i_up_valid = 1'b0;
    i_dn_ready = 1'b1;
    cyc();
    w_rstn_btn_db = 1'b1;

    // ---- boundary coincident with the 16th beat
    cyc();
    chk("post_rst_wait", o_state, 2'd1);
    vs_pulse();
    cyc();
    for (int i = 0; i < 15; i++) beat(12'h800 + 12'(i), 1'b1);
    vs_pulse();
    beat(12'h80F, 1'b1);
    chk("coinc_done", o_frame_done, 1'b1);
    chk("coinc_no_short", o_err_short, 1'b0);
    chk("coinc_cnt", o_frame_cnt, 16'd1);
    chk("coinc_state", o_state, 2'd2);
    for (int i = 0; i < 16; i++) beat(12'h900 + 12'(i), 1'b1);
    i_up_valid = 1'b1;
    #1;
    chk("next_full_valid", o_dn_valid, 1'b0);
    chk("next_full_ready", o_up_ready, 1'b1);
    i_up_valid = 1'b0;
    cyc();
    chk("coinc_no_long", o_err_long, 1'b0);
    chk("fd_total", fd_cnt, 7);
    sb_check("sb_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
- Frame-level sequencer inserted on the cam_top -> vp_top valid/ready link, in the i_top_clk domain.
- Gates pixel flow to frame boundaries, taken from the camera VSYNC after synchronisation.
- Supports continuous run, single-frame snapshot and freeze of the last frame.
- Counts pixels per frame, flags short/long frames and counts completed frames for the user-control logic.

Parameters:
- DW, 12, pixel data width (RGB444 from cam_top).
- PIX_PER_FRAME, 307200, expected beats per frame (640x480).
- CW, 19, pixel counter width; must satisfy 2^CW > PIX_PER_FRAME.

Ports:
- i_top_clk  in  1  system clock.
- w_rstn_btn_db  in  1  reset, asynchronous, active-low.
- i_cam_done  in  1  camera configuration complete (level, i_top_clk domain).
- i_vsync_async  in  1  raw camera VSYNC (pclk domain); synchronised internally.
- i_run  in  1  level: 1 = continuous streaming, 0 = freeze at next boundary.
- i_snap  in  1  one-cycle pulse: capture exactly one frame, then freeze.
- i_err_clr  in  1  one-cycle pulse: clear sticky error flags.
- i_up_valid  in  1  pixel valid from cam_top.
- i_up_data  in  DW  pixel from cam_top.
- o_up_ready  out  1  ready to cam_top.
- o_dn_valid  out  1  pixel valid to vp_top.
- o_dn_data  out  DW  pixel to vp_top.
- i_dn_ready  in  1  ready from vp_top.
- o_state  out  2  current state encoding.
- o_frame_done  out  1  one-cycle pulse at the end of each streamed frame.
- o_frame_cnt  out  16  completed streamed frames; wraps 0xFFFF -> 0.
- o_err_short  out  1  sticky: a frame ended with fewer than PIX_PER_FRAME beats.
- o_err_long  out  1  sticky: beats beyond PIX_PER_FRAME were dropped.

Behaviour:
- Reset (async assert, sync release by upstream synchroniser):
  - state = IDLE; pixel count = 0; o_frame_cnt = 0; snap_pend = 0.
  - o_err_short = o_err_long = 0; o_frame_done = 0.
  - o_dn_valid = 0; o_up_ready = 1.
- VSYNC path:
  - 2-FF synchroniser followed by an edge register.
  - Frame boundary (fb) = falling edge of the synchronised VSYNC; latency 3 cycles from the input.
- Snap latch: an i_snap pulse sets snap_pend in any state. snap_pend clears on entry to FROZEN or IDLE.
- States:
  - IDLE = 0, WAIT_SOF = 1, STREAM = 2, FROZEN = 3.
- Transitions:
  - IDLE -> WAIT_SOF: i_cam_done && (i_run || snap_pend).
  - WAIT_SOF -> STREAM on fb; pixel count = 0.
  - STREAM on fb:
    - o_frame_done = 1 and o_frame_cnt += 1.
    - If count < PIX_PER_FRAME, set o_err_short.
    - If snap_pend or !i_run -> FROZEN; otherwise stay in STREAM with count = 0.
  - FROZEN -> WAIT_SOF: i_cam_done && (snap_pend || i_run).
  - Any state, when i_cam_done = 0 -> IDLE:
    - Count cleared; no o_frame_done pulse.
    - o_frame_cnt and error flags are unaffected.
- Handshake, combinational, zero latency:
  - o_dn_data = i_up_data at all times.
  - In STREAM with count < PIX_PER_FRAME: o_dn_valid = i_up_valid and o_up_ready = i_dn_ready. A beat is a cycle with i_up_valid && i_dn_ready; it increments the count.
  - In STREAM with count == PIX_PER_FRAME: o_dn_valid = 0 and o_up_ready = 1. Each accepted beat is dropped and sets o_err_long; the count saturates.
  - In IDLE, WAIT_SOF and FROZEN: o_dn_valid = 0 and o_up_ready = 1, so cam_top drains and does not back up.
  - Once o_dn_valid is asserted, it stays asserted with stable data until i_dn_ready, provided cam_top holds valid; valid is never withdrawn mid-frame by this block.
- Simultaneous events:
  - Beat in the fb cycle: belongs to the ending frame and is counted before the short-frame check. The new frame count starts at 0 the next cycle.
  - fb and i_cam_done falling in the same cycle: IDLE wins; no o_frame_done pulse.
  - i_err_clr and an error set in the same cycle: the set wins.
  - i_snap while in STREAM: the current frame completes, then the block goes to FROZEN.
- Mid-frame reset: the downstream handshake is abandoned immediately; vp_top must tolerate a partial line.

Decomposition:
- Package frame_seq_pkg:
  - State localparams IDLE, WAIT_SOF, STREAM, FROZEN (2-bit).
  - Default PIX_PER_FRAME and derived CW.
- One sub-module: vsync_sync_edge, a 2-FF synchroniser plus rise/fall pulse outputs. It is reusable for HREF and other pclk-domain strobes.

Test Plan (PIX_PER_FRAME = 16, CW = 5):
- Reset, then i_cam_done = 1, i_run = 1, one VSYNC pulse, 16 beats, next fb -> state goes 0 -> 1 -> 2; o_frame_done pulses once; o_frame_cnt = 1; no error flags.
- Only 10 beats before fb -> o_err_short = 1. i_err_clr -> 0. 20 beats offered -> 16 passed downstream, 4 dropped, o_err_long = 1.
- i_run = 0 with an i_snap pulse in FROZEN -> exactly one frame of 16 beats passed, then state = 3. Upstream keeps o_up_ready = 1 while o_dn_valid stays 0.
- Random i_dn_ready backpressure (50%) during STREAM -> o_dn_valid and o_dn_data stay stable while stalled. Exactly 16 downstream beats are scoreboarded in order.
- i_cam_done dropped mid-frame (count = 7) -> IDLE next cycle; no o_frame_done pulse; o_frame_cnt unchanged. Async reset asserted mid-beat -> all outputs at reset values immediately.
- fb coincident with the 16th beat -> beat counted in the ending frame, no o_err_short; the next frame starts at count 0.
